// File: rtl/product_accumulator.sv
// product_accumulator
//
// Sums a programmable number of consecutive unsigned products into one
// saturating sum and presents each completed sum on a valid/ready output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a valid product
//   in_ready   a beat is accepted this cycle
//   in_data    unsigned product (WIDTH_IN bits)
//   cfg_len    products per block, 0 means 2^LEN_W (sampled on a block's first beat)
//   out_valid  completed sum available
//   out_ready  consumer takes the sum
//   out_sum    accumulated sum, clamped to all-ones on overflow
//   out_sat    overflow happened somewhere in this block
module product_accumulator #(
    parameter int unsigned WIDTH_IN  = 18,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned WIDTH_ACC = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  in_data,
    input  logic [LEN_W-1:0]     cfg_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_ACC-1:0] out_sum,
    output logic                 out_sat
);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StHold
    } state_e;

    state_e               state_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W:0]       count_q;
    logic [WIDTH_ACC-1:0] acc_q;
    logic                 sat_q;

    logic [WIDTH_ACC:0]   sum_full;
    logic [WIDTH_ACC-1:0] acc_add;
    logic                 add_ovf;
    logic [LEN_W:0]       count_inc;
    logic [LEN_W:0]       eff_len;
    logic                 first_is_last;

    // One bit of headroom catches the carry out of the accumulator.
    assign sum_full  = {1'b0, acc_q} + (WIDTH_ACC + 1)'(in_data);
    assign add_ovf   = sum_full[WIDTH_ACC];
    assign acc_add   = add_ovf ? '1 : sum_full[WIDTH_ACC-1:0];
    assign count_inc = count_q + (LEN_W + 1)'(1);

    // A zero length field encodes the maximum block length 2^LEN_W.
    assign eff_len = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};

    assign first_is_last = (cfg_len == LEN_W'(1));

    // Only out_ready reaches in_ready combinationally, and only while holding a result.
    assign in_ready  = (state_q != StHold) || out_ready;
    assign out_valid = (state_q == StHold);
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        len_q   <= cfg_len;
                        acc_q   <= WIDTH_ACC'(in_data);
                        count_q <= (LEN_W + 1)'(1);
                        sat_q   <= 1'b0;
                        state_q <= first_is_last ? StHold : StAcc;
                    end
                end
                StAcc: begin
                    if (in_valid) begin
                        acc_q   <= acc_add;
                        sat_q   <= sat_q | add_ovf;
                        count_q <= count_inc;
                        if (count_inc == eff_len) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Result taken and next block starts on the same edge.
                            len_q   <= cfg_len;
                            acc_q   <= WIDTH_ACC'(in_data);
                            count_q <= (LEN_W + 1)'(1);
                            sat_q   <= 1'b0;
                            state_q <= first_is_last ? StHold : StAcc;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int unsigned WIDTH_IN  = 18;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned WIDTH_ACC = 20;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH_IN-1:0]  in_data;
    logic [LEN_W-1:0]     cfg_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_ACC-1:0] out_sum;
    logic                 out_sat;

    int tests_run;
    int tests_failed;

    product_accumulator #(
        .WIDTH_IN  (WIDTH_IN),
        .LEN_W     (LEN_W),
        .WIDTH_ACC (WIDTH_ACC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_len   (cfg_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; outputs are stable when this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [WIDTH_IN-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_len = '0; out_ready = 1'b1;
        #3;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (out_sum !== 20'd0 || out_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_sum_sat: got %0d/%b want 0/0", out_sum, out_sat);
        end
        #10 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int hi_cycles;
        out_ready = 1'b1;
        cfg_len = 4'd3;
        beat(18'd100);
        beat(18'd200);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
        beat(18'd300);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd600 || out_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_sum: got v=%b sum=%0d sat=%b want v=1 sum=600 sat=0",
                     out_valid, out_sum, out_sat);
        end
        hi_cycles = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid === 1'b1) hi_cycles++;
        end
        tests_run++;
        if (hi_cycles != 1) begin
            tests_failed++; $display("FAIL basic_valid_width: got %0d cycles want 1", hi_cycles);
        end
    endtask

    task automatic test_saturation();
        cfg_len = 4'd5;
        for (int i = 0; i < 5; i++) beat(18'd262143);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd1048575 || out_sat !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_block: got v=%b sum=%0d sat=%b want v=1 sum=1048575 sat=1",
                     out_valid, out_sum, out_sat);
        end
        step();
        cfg_len = 4'd2;
        beat(18'd1);
        beat(18'd2);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd3 || out_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_next_block: got v=%b sum=%0d sat=%b want v=1 sum=3 sat=0",
                     out_valid, out_sum, out_sat);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        cfg_len = 4'd2;
        beat(18'd5);
        beat(18'd6);
        in_data = 18'd9;  // in_valid stays high
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 20'd11) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b sum=%0d want rdy=0 v=1 sum=11",
                         i, in_ready, out_valid, out_sum);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_taken: got v=%b want 0", out_valid);
        end
        beat(18'd4);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd13) begin
            tests_failed++;
            $display("FAIL bp_next_sum: got v=%b sum=%0d want v=1 sum=13", out_valid, out_sum);
        end
        step();
    endtask

    task automatic test_len_edges();
        cfg_len = 4'd0;
        for (int i = 0; i < 15; i++) beat(18'd1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL len0_early: got v=%b want 0", out_valid);
        end
        beat(18'd1);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd16) begin
            tests_failed++;
            $display("FAIL len0_sum: got v=%b sum=%0d want v=1 sum=16", out_valid, out_sum);
        end
        step();
        cfg_len = 4'd1;
        beat(18'd7);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd7) begin
            tests_failed++;
            $display("FAIL len1_sum: got v=%b sum=%0d want v=1 sum=7", out_valid, out_sum);
        end
        step();
        beat(18'd4);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                in_valid = 1'b1; in_data = 18'(5 + i);
            end else begin
                in_valid = 1'b0;
            end
            tests_run++;
            if (out_valid !== 1'b1 || out_sum !== 20'(4 + i)) begin
                tests_failed++;
                $display("FAIL len1_b2b[%0d]: got v=%b sum=%0d want v=1 sum=%0d",
                         i, out_valid, out_sum, 4 + i);
            end
            step();
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL len1_b2b_end: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        cfg_len = 4'd3;
        beat(18'd50);
        beat(18'd60);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 20'd0 || out_sat !== 1'b0)
        begin
            tests_failed++;
            $display("FAIL rst_mid: got rdy=%b v=%b sum=%0d sat=%b want 1/0/0/0",
                     in_ready, out_valid, out_sum, out_sat);
        end
        #1 rst_n = 1'b1;
        step();
        beat(18'd1);
        beat(18'd2);
        beat(18'd3);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd6) begin
            tests_failed++;
            $display("FAIL rst_after: got v=%b sum=%0d want v=1 sum=6", out_valid, out_sum);
        end
        step();
    endtask

    task automatic test_bubbles();
        int early;
        early = 0;
        cfg_len = 4'd4;
        beat(18'd10);
        cfg_len = 4'd2;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b0;
            step();
            if (out_valid !== 1'b0) early++;
            step();
            if (out_valid !== 1'b0) early++;
            beat(18'(20 + 10 * b));
            if (b < 2 && out_valid !== 1'b0) early++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (early != 0) begin
            tests_failed++; $display("FAIL bubble_early: got %0d early valid cycles want 0", early);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 20'd100 || out_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_sum: got v=%b sum=%0d sat=%b want v=1 sum=100 sat=0",
                     out_valid, out_sum, out_sat);
        end
        step();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_len_edges();
        test_reset_mid();
        test_bubbles();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
